bit_serial_result_collector: RTL

//  Downstream of the bit-serial adder tree set. Deserializes the per-lane
//  LSB-first serial sums (WORD_BITS bits each) into parallel two's-complement

---
 rtl/bit_serial_result_collector.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bit_serial_result_collector.sv
// Turns per-lane LSB-first serial sums back into parallel words, optionally
// sums groups of them, and queues the results for a valid/ready consumer.

module bscr_lane #(
    parameter int WORD_BITS = 32,
    parameter int CW        = $clog2(WORD_BITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_en,
    input  logic                 bit_in,
    input  logic [CW-1:0]        bit_cnt,
    input  logic                 word_done,
    input  logic                 first_word,
    output logic [WORD_BITS-1:0] sum
);
    logic [WORD_BITS-1:0] sh;
    logic [WORD_BITS-1:0] acc;
    logic [WORD_BITS-1:0] word;

    // The completing bit is merged in combinationally so the word needs no extra cycle.
    always_comb begin
        word          = sh;
        word[bit_cnt] = bit_in;
        sum           = first_word ? word : acc + word;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sh  <= '0;
            acc <= '0;
        end else begin
            if (serial_en) sh[bit_cnt] <= bit_in;
            if (word_done) acc <= sum;
        end
    end
endmodule

module bit_serial_result_collector #(
    parameter int LANES      = 8,
    parameter int WORD_BITS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          serial_en,
    input  logic [LANES-1:0]              serial_in,
    input  logic [7:0]                    acc_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*WORD_BITS-1:0]    out_data,
    output logic                          overflow,
    output logic [$clog2(WORD_BITS)-1:0]  bit_cnt
);
    localparam int CW = $clog2(WORD_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = LANES * WORD_BITS;

    logic [7:0] word_cnt;
    logic [7:0] grp_len;
    logic [7:0] len_eff;
    logic       word_done;
    logic       first_word;
    logic       last_word;
    logic       push;

    logic [LANES-1:0][WORD_BITS-1:0] lane_sum;
    logic [DW-1:0]                   push_data;

    assign word_done  = serial_en && (bit_cnt == CW'(WORD_BITS - 1));
    assign first_word = (word_cnt == 8'd0);
    // Group length is only sampled on the first word; later acc_len changes wait for the next group.
    assign len_eff    = first_word ? ((acc_len == 8'd0) ? 8'd1 : acc_len) : grp_len;
    assign last_word  = ({1'b0, word_cnt} + 9'd1) == {1'b0, len_eff};
    assign push       = word_done && last_word;
    assign push_data  = lane_sum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            grp_len  <= 8'd1;
        end else if (serial_en) begin
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
            if (word_done) begin
                word_cnt <= last_word ? 8'd0 : word_cnt + 8'd1;
                if (first_word) grp_len <= len_eff;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            bscr_lane #(.WORD_BITS(WORD_BITS), .CW(CW)) u_lane (
                .clk        (clk),
                .reset      (reset),
                .serial_en  (serial_en),
                .bit_in     (serial_in[k]),
                .bit_cnt    (bit_cnt),
                .word_done  (word_done),
                .first_word (first_word),
                .sum        (lane_sum[k])
            );
        end
    endgenerate

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          pop;
    logic          full;
    logic          push_ok;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // out_data is a registered copy of the head so it holds its last value once empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            out_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push_ok) count <= count - (PW+1)'(1);
            if (push && !push_ok) overflow <= 1'b1;
            if (pop) begin
                if (count > (PW+1)'(1)) out_data <= mem[rd_ptr + PW'(1)];
                else if (push_ok)       out_data <= push_data;
            end else if (push_ok && count == '0) begin
                out_data <= push_data;
            end
        end
    end
endmodule
